// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt front end for the OTTER MCU.
// Synchronises raw interrupt lines, edge-detects them into pending bits,
// picks the lowest-index enabled source and tracks the service window
// from the take pulse until mret.
module intr_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int CAUSE_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               INTR_CLK,
    input  logic               INTR_RST_N,
    input  logic [NUM_SRC-1:0] INTR_SRC,
    input  logic [NUM_SRC-1:0] INTR_MASK,
    input  logic               INTR_MIE,
    input  logic               INTR_BOUNDARY,
    input  logic               INTR_MRET,
    output logic               INTR_INT_TAKEN,
    output logic [CAUSE_W-1:0] INTR_CAUSE,
    output logic               INTR_IN_SERVICE,
    output logic [NUM_SRC-1:0] INTR_PENDING
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [NUM_SRC-1:0]   sync1;
    logic [NUM_SRC-1:0]   sync2;
    logic [NUM_SRC-1:0]   prev;
    logic [NUM_SRC-1:0]   pending;
    logic [NUM_SRC-1:0]   rise;
    logic [NUM_SRC-1:0]   eligible;
    logic [NUM_SRC-1:0]   clr_mask;
    logic [CAUSE_W-1:0]   winner;
    logic [CAUSE_W-1:0]   cause;
    logic                 take_cond;

    // Two-flop synchroniser plus a previous-sample flop for edge detection.
    always_ff @(posedge INTR_CLK or negedge INTR_RST_N) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, as real flops do.
        if (!INTR_RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= INTR_SRC;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise      = sync2 & ~prev;
    assign eligible  = pending & INTR_MASK;
    assign take_cond = (state == ST_IDLE) && INTR_MIE && INTR_BOUNDARY && (eligible != '0);

    // Fixed-priority encoder: lowest-index eligible source wins.
    always_comb begin
        // NOTE: default first, so no path through the loop leaves winner
        // unassigned and infers a latch.
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = CAUSE_W'(i);
            end
        end
    end

    // One-hot of the winning source (isolate lowest set bit), only on a take.
    assign clr_mask = take_cond ? (eligible & (~eligible + NUM_SRC'(1))) : '0;

    // Pending bits: clear the taken source, then OR in new edges so a
    // same-cycle rise on the winner keeps it pending.
    always_ff @(posedge INTR_CLK or negedge INTR_RST_N) begin
        if (!INTR_RST_N) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | rise;
        end
    end

    // Cause register: captured on the take, held otherwise.
    always_ff @(posedge INTR_CLK or negedge INTR_RST_N) begin
        if (!INTR_RST_N) begin
            cause <= '0;
        end else if (take_cond) begin
            cause <= winner;
        end
    end

    // State register.
    always_ff @(posedge INTR_CLK or negedge INTR_RST_N) begin
        if (!INTR_RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> TAKE -> SERVICE -> (mret) IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (take_cond) state_next = ST_TAKE;
            ST_TAKE:    state_next = ST_SERVICE;
            ST_SERVICE: if (INTR_MRET) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        INTR_INT_TAKEN  = (state == ST_TAKE);
        INTR_IN_SERVICE = (state == ST_TAKE) || (state == ST_SERVICE);
    end

    assign INTR_CAUSE   = cause;
    assign INTR_PENDING = pending;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed vectors for intr_ctrl with a take scoreboard.
// Stimulus pushes the expected cause/pending of each take; a monitor pops
// and compares whenever INT_TAKEN is seen high.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] src = '0;
    logic [3:0] mask = 4'hF;
    logic       mie = 1'b1;
    logic       boundary = 1'b1;
    logic       mret = 1'b0;
    logic       int_taken;
    logic [1:0] cause;
    logic       in_service;
    logic [3:0] pending;

    typedef struct {
        logic [1:0] cause;
        logic [3:0] pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    intr_ctrl #(.NUM_SRC(4)) dut (
        .INTR_CLK        (clk),
        .INTR_RST_N      (rst_n),
        .INTR_SRC        (src),
        .INTR_MASK       (mask),
        .INTR_MIE        (mie),
        .INTR_BOUNDARY   (boundary),
        .INTR_MRET       (mret),
        .INTR_INT_TAKEN  (int_taken),
        .INTR_CAUSE      (cause),
        .INTR_IN_SERVICE (in_service),
        .INTR_PENDING    (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] c, input logic [3:0] p);
        exp_t e;
        e.cause = c;
        e.pend  = p;
        sb_q.push_back(e);
    endtask

    task automatic mret_pulse();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    // Monitor: every cycle with INT_TAKEN high must match a queued take.
    always @(negedge clk) begin
        if (rst_n && int_taken) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_take: got cause %0d with no take expected", cause);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("take_cause", 32'(cause), 32'(e.cause));
                check("take_pending", 32'(pending), 32'(e.pend));
                check("take_in_service", 32'(in_service), 32'd1);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        tick(2);
        check("rst_taken", 32'(int_taken), 32'd0);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_in_service", 32'(in_service), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Latency: source 2 rises, sampled at edge k
        src = 4'b0100;
        tick();                                  // after edge k
        tick();                                  // after k+1
        check("lat_pend_k1", 32'(pending), 32'h0);
        tick();                                  // after k+2
        check("lat_pend_k2", 32'(pending), 32'h4);
        check("lat_taken_k2", 32'(int_taken), 32'd0);
        push(2'd2, 4'b0000);
        tick();                                  // after k+3
        check("lat_taken_k3", 32'(int_taken), 32'd1);
        check("lat_cause", 32'(cause), 32'd2);
        check("lat_pend_k3", 32'(pending), 32'h0);
        tick();                                  // after k+4
        check("lat_taken_k4", 32'(int_taken), 32'd0);
        check("lat_in_service", 32'(in_service), 32'd1);
        src = 4'b0000;
        mret_pulse();
        check("lat_after_mret", 32'(in_service), 32'd0);
        tick(4);

        // Priority: sources 1 and 3 together
        src = 4'b1010;
        tick(3);
        push(2'd1, 4'b1000);
        tick();
        check("pri_first_cause", 32'(cause), 32'd1);
        check("pri_pend_after", 32'(pending), 32'h8);
        boundary = 1'b0;
        tick(3);
        check("pri_pend_hold", 32'(pending), 32'h8);
        check("pri_in_service", 32'(in_service), 32'd1);
        mret_pulse();
        tick(2);
        check("pri_idle_no_take", 32'(int_taken), 32'd0);
        check("pri_idle", 32'(in_service), 32'd0);
        check("pri_pend_idle", 32'(pending), 32'h8);
        push(2'd3, 4'b0000);
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        check("pri_second_taken", 32'(int_taken), 32'd1);
        check("pri_second_cause", 32'(cause), 32'd3);
        src = 4'b0000;
        tick();
        mret_pulse();
        tick(4);

        // Gating: MIE low blocks take, pending untouched
        mie = 1'b0;
        boundary = 1'b1;
        src = 4'b0001;
        tick(3);
        check("gate_pend_set", 32'(pending), 32'h1);
        tick(20);
        check("gate_pend_hold", 32'(pending), 32'h1);
        check("gate_no_take", 32'(int_taken), 32'd0);
        check("gate_cause_held", 32'(cause), 32'd3);
        mie = 1'b1;
        push(2'd0, 4'b0000);
        tick();
        check("gate_taken", 32'(int_taken), 32'd1);
        check("gate_cause", 32'(cause), 32'd0);
        src = 4'b0000;
        tick();
        mret_pulse();
        tick(4);

        // Masking and coalescing: three pulses on masked source 0
        mask = 4'b1110;
        for (int p = 0; p < 3; p++) begin
            src = 4'b0001;
            tick(2);
            src = 4'b0000;
            tick(2);
        end
        tick(3);
        check("mask_pend", 32'(pending), 32'h1);
        check("mask_no_take", 32'(in_service), 32'd0);
        mask = 4'hF;
        push(2'd0, 4'b0000);
        tick();
        check("mask_taken", 32'(int_taken), 32'd1);
        check("mask_cause", 32'(cause), 32'd0);
        tick();
        mret_pulse();
        tick(5);
        check("mask_single_take", 32'(pending), 32'h0);

        // Collision: rise on source 2 in the cycle it is taken
        mie = 1'b0;
        src = 4'b0100;
        tick(2);
        src = 4'b0000;
        tick(4);
        check("col_pend_pre", 32'(pending), 32'h4);
        src = 4'b0100;
        tick();                                  // after edge k
        tick();                                  // after k+1, rise live now
        mie = 1'b1;
        push(2'd2, 4'b0100);
        tick();                                  // after k+2: TAKE
        check("col_taken", 32'(int_taken), 32'd1);
        check("col_cause", 32'(cause), 32'd2);
        check("col_pend_kept", 32'(pending), 32'h4);
        mret = 1'b1;                             // mret during TAKE: ignored
        tick();
        mret = 1'b0;
        check("col_mret_ignored", 32'(in_service), 32'd1);
        tick();
        check("col_still_service", 32'(in_service), 32'd1);
        check("col_no_retake", 32'(int_taken), 32'd0);
        src = 4'b0000;
        push(2'd2, 4'b0000);
        mret_pulse();
        tick();
        check("col_retake", 32'(int_taken), 32'd1);
        tick();

        // Reset mid-service with pending 0110
        src = 4'b0110;
        tick(3);
        src = 4'b0000;
        check("rst2_pend", 32'(pending), 32'h6);
        check("rst2_service", 32'(in_service), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst2_taken", 32'(int_taken), 32'd0);
        check("rst2_cause", 32'(cause), 32'd0);
        check("rst2_in_service", 32'(in_service), 32'd0);
        check("rst2_pending", 32'(pending), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("rst2_quiet_service", 32'(in_service), 32'd0);
        check("rst2_quiet_pend", 32'(pending), 32'h0);

        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d takes outstanding expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt front end for the OTTER MCU; sits directly upstream of the CSR block.
- Synchronises asynchronous external interrupt lines and rising-edge-detects them into per-source pending bits.
- Arbitrates by fixed priority and issues the one-cycle INT_TAKEN pulse the CSR and PC-select logic consume.
- Tracks in-service state until mret, so exactly one interrupt is taken per service window.

Parameters:
- NUM_SRC, 4: number of external interrupt sources, range 1..16.
- CAUSE_W, $clog2(NUM_SRC) (min 1): width of the cause index.

Ports:
- INTR_CLK  in  1  system clock; all state updates on its rising edge.
- INTR_RST_N  in  1  asynchronous, active-low reset.
- INTR_SRC  in  NUM_SRC  raw asynchronous interrupt lines; a rising edge is an event.
- INTR_MASK  in  NUM_SRC  per-source enable; 1 = source may be taken.
- INTR_MIE  in  1  global enable, driven by MSTATUS bit 3 from the CSR.
- INTR_BOUNDARY  in  1  high for one cycle at an instruction boundary, from the control FSM.
- INTR_MRET  in  1  mret executing, same signal the CSR receives.
- INTR_INT_TAKEN  out  1  one-cycle take pulse to the CSR and control FSM.
- INTR_CAUSE  out  CAUSE_W  index of the source taken or in service.
- INTR_IN_SERVICE  out  1  high from the take pulse until mret.
- INTR_PENDING  out  NUM_SRC  current pending bits, masked or not.

Behaviour:
Reset (INTR_RST_N low, asynchronous):
- State goes to IDLE.
- Sync flops, previous-sample flops and pending all clear to 0.
- INTR_INT_TAKEN=0, INTR_CAUSE=0, INTR_IN_SERVICE=0, INTR_PENDING=0.
- The same applies when reset arrives mid-service: the in-flight interrupt is dropped and no mret is needed afterwards.

Synchroniser:
- Each line uses two flops (s1, s2) plus one previous-sample flop (p).
- rise[i] = s2[i] & ~p[i].
- A line high at edge k gives s1 at k, s2 at k+1, pending[i] set at edge k+2.
- Lines held high generate exactly one event; a new event requires a low-then-high transition.
- Events that repeat while pending[i] is already set coalesce into one.

Arbitration:
- eligible = pending & INTR_MASK.
- The winner is the lowest-index set bit of eligible.
- take_cond = (state==IDLE) & INTR_MIE & INTR_BOUNDARY & (eligible != 0).

State machine:
- IDLE: if take_cond, go to TAKE at the next edge. At that same edge, INTR_CAUSE <= winner and pending[winner] <= 0.
- TAKE: INTR_INT_TAKEN=1 and INTR_IN_SERVICE=1 (both decoded from registered state). Go to SERVICE unconditionally.
- SERVICE: INTR_IN_SERVICE=1. If INTR_MRET, go to IDLE.
- Latency: INTR_INT_TAKEN rises exactly one cycle after the cycle in which take_cond is true.

Boundary conditions:
- Set/clear collision: if rise[winner] is true in the same cycle pending[winner] is cleared by the take, the set wins and pending stays 1.
- Events arriving during TAKE/SERVICE accumulate in pending.
- After mret returns the block to IDLE, the next take can occur at the first following cycle with take_cond true.
- INTR_MRET in IDLE or TAKE is ignored.
- INTR_MIE low or INTR_BOUNDARY low blocks a take but never clears pending.
- Masked sources still set pending and are taken once unmasked.
- INTR_CAUSE holds its last value in IDLE.

Test Plan:
- Reset: assert INTR_RST_N=0 mid-SERVICE with INTR_PENDING=4'b0110 -> all outputs 0 immediately (asynchronously), state IDLE; after release no INT_TAKEN without new events.
- Latency: INTR_SRC[2] 0->1 sampled at edge k, MASK=4'hF, MIE=1, BOUNDARY=1 continuously -> PENDING[2]=1 after edge k+2, INT_TAKEN high for exactly the cycle after edge k+3, CAUSE=2, PENDING[2]=0.
- Priority and ordering: rises on sources 1 and 3 in the same cycle -> first take has CAUSE=1; PENDING=4'b1000 stays set; after an INTR_MRET pulse and a boundary, second take has CAUSE=3.
- Gating: MIE=0 with PENDING=4'b0001 for 20 cycles -> no take, PENDING unchanged; raise MIE at a boundary cycle -> INT_TAKEN next cycle, CAUSE=0.
- Masking and coalescing: MASK=4'b1110 and three pulses on source 0 -> PENDING=4'b0001, no take; set MASK=4'hF -> exactly one take with CAUSE=0.
- Collision: new rise on source 2 in the same cycle source 2 is taken -> INT_TAKEN with CAUSE=2, PENDING[2] remains 1; INTR_MRET issued during TAKE is ignored and IN_SERVICE stays 1.
